instr_decode_queue: RTL and testbench
=====================================

INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, 2..16.
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the PC and target outputs; at least 28.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: the producer offers an instruction.
REQ-006 Port in_ready, output, 1 bit: the queue accepts the offered instruction.
REQ-007 Port in_instr, input, 32 bits: raw instruction word.
REQ-008 Port in_pc, input, PC_W bits: address of in_instr.
REQ-009 Port flush, input, 1 bit: synchronously discard all entries.
REQ-010 Port out_valid, output, 1 bit: the head entry is presented.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the head entry.
REQ-012 Outputs out_opcode (6), out_rs (5), out_rt (5), out_rd (5), out_shamt (5), out_funct (6), out_imm16 (16), out_address (26): the MIPS fields of the head entry.
REQ-013 Outputs out_imm_sext (32) and out_imm_zext (32): imm16 sign-extended and zero-extended.
REQ-014 Output out_pc (PC_W): PC of the head entry.
REQ-015 Output out_jump_target (PC_W): {(pc+4)[PC_W-1:28], address, 2'b00}.
REQ-016 Output out_branch_target (PC_W): pc + 4 + (imm_sext << 2), truncated modulo 2^PC_W.
REQ-017 Output out_count, clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-018 Push occurs when in_valid and in_ready are both high; pop occurs when out_valid and out_ready are both high.
REQ-019 in_ready SHALL be high exactly when out_count < DEPTH; there is no pass-through when full.
REQ-020 out_valid SHALL be high exactly when out_count > 0; there is no bypass, so latency from push to out_valid is 1 cycle.
REQ-021 All decoded outputs SHALL be combinational functions of the head entry, and SHALL be 0 while out_valid is low.
REQ-022 Simultaneous push and pop SHALL leave out_count unchanged and advance both pointers.
REQ-023 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 Entry order SHALL be strictly FIFO.
REQ-025 flush SHALL have priority over push and pop; in the next cycle out_count = 0 and both pointers = 0, and any push in the flush cycle is discarded.
REQ-026 in_valid with in_ready low SHALL have no effect; the producer holds its data.
REQ-027 A pop while empty, or a push while full, is impossible by construction and SHALL NOT change state.

Reset
REQ-028 Assertion of rst_n low SHALL immediately force out_count = 0, both pointers = 0, out_valid = 0 and in_ready = 1, at any point including mid-stream.
REQ-029 Storage contents need not be reset; decoded outputs SHALL read 0 because of REQ-021.

Structure
REQ-030 A shared package SHALL hold the field bit positions and widths (OPCODE_MSB, RS_LSB, and so on) and the instruction width of 32.
REQ-031 A single sub-module, instr_field_split, SHALL perform the combinational field extraction; the queue instantiates it on the head entry.
REQ-032 Storage SHALL be a register array of DEPTH x (32 + PC_W) bits.

Verification
REQ-033 Push 0x2108FFFC at pc 0x00003000, then hold out_ready high. Required: opcode 0x08, rs 8, rt 8, imm16 0xFFFC, imm_sext 0xFFFFFFFC, imm_zext 0x0000FFFC, branch_target 0x00002FF4, one cycle after the push.
REQ-034 Push 0x08000C00 at pc 0x00003004. Required: opcode 0x02, address 0x0000C00, jump_target 0x00003000.
REQ-035 With DEPTH=4 and out_ready low, offer 5 pushes. Required: out_count reaches 4, in_ready goes to 0, and the 5th word is held. Then pop 4 times; the words SHALL appear in push order, after which out_valid = 0.
REQ-036 At out_count = 2, push and pop in the same cycle. Required: out_count stays 2. Continue for 10 cycles to cross pointer wrap; data order SHALL be preserved.
REQ-037 At out_count = 3, assert flush with in_valid high. Required: next cycle out_count = 0 and out_valid = 0; a new push is then output 1 cycle later.
REQ-038 Drop rst_n low between clock edges at out_count = 2. Required: out_valid = 0 and in_ready = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_decode_queue_pkg.sv
// rtl/instr_decode_queue_pkg.sv - MIPS instruction field layout shared by the decode queue
//
// Purpose: bit positions and widths of the MIPS instruction fields, plus a
// sign-extension helper for the 16-bit immediate.
// Ports: none (package).

package instr_decode_queue_pkg;

  localparam int INSTR_W = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RS_W   = 5;

  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RT_W   = 5;

  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int RD_W   = 5;

  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int SHAMT_W   = 5;

  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int FUNCT_W   = 6;

  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 26;

  // PC bits at and above this position are kept from pc+4 in a jump target.
  localparam int JUMP_REGION_LSB = 28;

  function automatic logic [INSTR_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// rtl/instr_field_split.sv - combinational MIPS field extraction
//
// Purpose: slices a 32-bit MIPS word into its R/I/J fields and produces the
// sign- and zero-extended immediate.
// Ports:
//   i_instr      - instruction word
//   o_opcode, o_rs, o_rt, o_rd, o_shamt, o_funct, o_imm16, o_address - fields
//   o_imm_sext   - imm16 sign-extended to 32 bits
//   o_imm_zext   - imm16 zero-extended to 32 bits

module instr_field_split
  import instr_decode_queue_pkg::*;
(
  input  logic [INSTR_W-1:0]  i_instr,
  output logic [OPCODE_W-1:0] o_opcode,
  output logic [RS_W-1:0]     o_rs,
  output logic [RT_W-1:0]     o_rt,
  output logic [RD_W-1:0]     o_rd,
  output logic [SHAMT_W-1:0]  o_shamt,
  output logic [FUNCT_W-1:0]  o_funct,
  output logic [IMM_W-1:0]    o_imm16,
  output logic [ADDR_W-1:0]   o_address,
  output logic [INSTR_W-1:0]  o_imm_sext,
  output logic [INSTR_W-1:0]  o_imm_zext
);

  assign o_opcode   = i_instr[OPCODE_MSB:OPCODE_LSB];
  assign o_rs       = i_instr[RS_MSB:RS_LSB];
  assign o_rt       = i_instr[RT_MSB:RT_LSB];
  assign o_rd       = i_instr[RD_MSB:RD_LSB];
  assign o_shamt    = i_instr[SHAMT_MSB:SHAMT_LSB];
  assign o_funct    = i_instr[FUNCT_MSB:FUNCT_LSB];
  assign o_imm16    = i_instr[IMM_MSB:IMM_LSB];
  assign o_address  = i_instr[ADDR_MSB:ADDR_LSB];
  assign o_imm_sext = sext_imm(i_instr[IMM_MSB:IMM_LSB]);
  assign o_imm_zext = {{(INSTR_W-IMM_W){1'b0}}, i_instr[IMM_MSB:IMM_LSB]};

endmodule

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - FIFO of fetched instructions with decoded head entry
//
// Purpose: buffers {instruction, pc} pairs and presents the head entry already
// split into MIPS fields, with jump and branch targets computed.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_valid/in_ready       - producer handshake; in_instr, in_pc carry the entry
//   flush                   - discards all entries (wins over push and pop)
//   out_valid/out_ready     - consumer handshake on the head entry
//   out_opcode..out_address - head fields; out_imm_sext/out_imm_zext - immediates
//   out_pc, out_jump_target, out_branch_target - head PC and targets
//   out_count               - occupied entries

module instr_decode_queue
  import instr_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_W-1:0]      out_opcode,
  output logic [RS_W-1:0]          out_rs,
  output logic [RT_W-1:0]          out_rt,
  output logic [RD_W-1:0]          out_rd,
  output logic [SHAMT_W-1:0]       out_shamt,
  output logic [FUNCT_W-1:0]       out_funct,
  output logic [IMM_W-1:0]         out_imm16,
  output logic [ADDR_W-1:0]        out_address,
  output logic [INSTR_W-1:0]       out_imm_sext,
  output logic [INSTR_W-1:0]       out_imm_zext,
  output logic [PC_W-1:0]          out_pc,
  output logic [PC_W-1:0]          out_jump_target,
  output logic [PC_W-1:0]          out_branch_target,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = INSTR_W + PC_W;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  PC_HI_MASK = ~PC_W'({JUMP_REGION_LSB{1'b1}});

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [INSTR_W-1:0] w_head_instr;
  logic [PC_W-1:0]    w_head_pc;
  logic [PC_W-1:0]    w_pc_plus4;
  logic [PC_W-1:0]    w_br_off;

  assign in_ready  = (r_count < FULL_CNT);
  assign out_valid = (r_count != '0);
  assign out_count = r_count;

  // A push in a flush cycle is dropped, so flush also gates the write.
  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_instr, in_pc};
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_instr = out_valid ? w_head[ENTRY_W-1:PC_W] : '0;
  assign w_head_pc    = out_valid ? w_head[PC_W-1:0] : '0;

  instr_field_split u_split (
    .i_instr    (w_head_instr),
    .o_opcode   (out_opcode),
    .o_rs       (out_rs),
    .o_rt       (out_rt),
    .o_rd       (out_rd),
    .o_shamt    (out_shamt),
    .o_funct    (out_funct),
    .o_imm16    (out_imm16),
    .o_address  (out_address),
    .o_imm_sext (out_imm_sext),
    .o_imm_zext (out_imm_zext)
  );

  assign w_pc_plus4 = w_head_pc + PC_W'(4);
  // Word offset sign-extended straight to PC_W so wide PCs stay correct.
  assign w_br_off   = {{(PC_W-IMM_W-2){out_imm16[IMM_W-1]}}, out_imm16, 2'b00};

  assign out_pc            = w_head_pc;
  assign out_jump_target   = out_valid ? ((w_pc_plus4 & PC_HI_MASK) | PC_W'({out_address, 2'b00})) : '0;
  assign out_branch_target = out_valid ? (w_pc_plus4 + w_br_off) : '0;

endmodule

// File: tb/tb_instr_decode_queue.sv
// tb/tb_instr_decode_queue.sv - scoreboard bench for instr_decode_queue

module tb_instr_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic [25:0] out_address;
  logic [31:0] out_imm_sext;
  logic [31:0] out_imm_zext;
  logic [31:0] out_pc;
  logic [31:0] out_jump_target;
  logic [31:0] out_branch_target;
  logic [2:0]  out_count;

  always #5 clk = ~clk;

  instr_decode_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .in_pc             (in_pc),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_opcode        (out_opcode),
    .out_rs            (out_rs),
    .out_rt            (out_rt),
    .out_rd            (out_rd),
    .out_shamt         (out_shamt),
    .out_funct         (out_funct),
    .out_imm16         (out_imm16),
    .out_address       (out_address),
    .out_imm_sext      (out_imm_sext),
    .out_imm_zext      (out_imm_zext),
    .out_pc            (out_pc),
    .out_jump_target   (out_jump_target),
    .out_branch_target (out_branch_target),
    .out_count         (out_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          chk_tgt;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [31:0] jt;
    logic [31:0] bt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares the head entry on every pop, and checks idle outputs are 0.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got instr fields 0x%0h expected none",
                 {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct});
      end else begin
        mon_e = sb.pop_front();
        chk("fields", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}, mon_e.instr);
        chk("imm16", out_imm16, mon_e.instr[15:0]);
        chk("address", out_address, mon_e.instr[25:0]);
        chk("pc", out_pc, mon_e.pc);
        if (mon_e.chk_tgt) begin
          chk("imm_sext", out_imm_sext, mon_e.sext);
          chk("imm_zext", out_imm_zext, mon_e.zext);
          chk("jump_target", out_jump_target, mon_e.jt);
          chk("branch_target", out_branch_target, mon_e.bt);
        end
      end
    end else if (!out_valid) begin
      chk("idle_zero", |{out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm16,
                         out_address, out_imm_sext, out_imm_zext, out_pc, out_jump_target,
                         out_branch_target}, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w, input logic [31:0] p, input bit track);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = p;
    if (track) sb.push_back('{instr: w, pc: p, chk_tgt: 1'b0, sext: 32'h0, zext: 32'h0, jt: 32'h0, bt: 32'h0});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_count", out_count, 0);
    step();
    step();
    rst_n = 1'b1;

    // ADDI-style word with negative immediate
    out_ready = 1'b1;
    offer(32'h2108FFFC, 32'h00003000, 1'b0);
    sb.push_back('{instr: 32'h2108FFFC, pc: 32'h00003000, chk_tgt: 1'b1, sext: 32'hFFFFFFFC,
                   zext: 32'h0000FFFC, jt: 32'h0423FFF0, bt: 32'h00002FF4});
    step();
    in_valid = 1'b0;
    chk("addi_valid_next_cycle", out_valid, 1);
    chk("addi_opcode", out_opcode, 6'h08);
    chk("addi_rs", out_rs, 8);
    chk("addi_rt", out_rt, 8);
    step();
    chk("addi_drained", out_count, 0);

    // J-format word
    offer(32'h08000C00, 32'h00003004, 1'b0);
    sb.push_back('{instr: 32'h08000C00, pc: 32'h00003004, chk_tgt: 1'b1, sext: 32'h00000C00,
                   zext: 32'h00000C00, jt: 32'h00003000, bt: 32'h00006008});
    step();
    in_valid = 1'b0;
    chk("j_opcode", out_opcode, 6'h02);
    chk("j_address", out_address, 26'h0000C00);
    chk("j_target", out_jump_target, 32'h00003000);
    step();

    // Fill to DEPTH, hold a 5th offer, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'hA0000000 + i, 32'h00000100 + 4 * i, 1'b1);
      step();
      chk("fill_count", out_count, i + 1);
    end
    chk("full_in_ready", in_ready, 0);
    offer(32'hA5A5A5A5, 32'h00000110, 1'b0);
    step();
    step();
    chk("full_held_count", out_count, 4);
    chk("full_held_ready", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_valid", out_valid, 0);
    chk("drain_count", out_count, 0);

    // Steady push+pop at count 2 across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(32'hC0000000 + i, 32'h00000200 + 4 * i, 1'b1);
      step();
    end
    chk("pp_start_count", out_count, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(32'hC0000010 + i, 32'h00000300 + 4 * i, 1'b1);
      step();
      chk("pp_count", out_count, 2);
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("pp_drain_valid", out_valid, 0);

    // Flush at count 3 with a concurrent push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'hD0000000 + i, 32'h00000400 + 4 * i, 1'b1);
      step();
    end
    chk("flush_pre_count", out_count, 3);
    flush = 1'b1;
    offer(32'hDEADBEEF, 32'h00000500, 1'b0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_count", out_count, 0);
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    offer(32'h3C01ABCD, 32'h00000600, 1'b1);
    step();
    in_valid = 1'b0;
    chk("post_flush_valid", out_valid, 1);
    step();
    chk("post_flush_drain", out_valid, 0);

    // Asynchronous reset mid-stream at count 2
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(32'hE0000000 + i, 32'h00000700 + 4 * i, 1'b1);
      step();
    end
    in_valid = 1'b0;
    chk("areset_pre_count", out_count, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_ready", in_ready, 1);
    chk("areset_count", out_count, 0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();

    // Queue still works after reset
    out_ready = 1'b1;
    offer(32'h8C220010, 32'h00000800, 1'b1);
    step();
    in_valid = 1'b0;
    chk("after_reset_valid", out_valid, 1);
    step();

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
